lift_output_pingpong_buffer: RTL and testbench

Parametrised, double-buffered output stage for the lift unit. It accepts a stream of DATA_W-bit lift coefficients, one per cycle, and packs them lane-interleaved into one of two banks of LANES parallel RAMs. Full banks are drained as LANES×DATA_W-bit rows through a valid/ready port toward the wide coefficient memory. While the reader drains one bank, the writer fills the other, so the lift pipeline does not stall between polynomials.

---
 rtl/lift_output_pingpong_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_lift_output_pingpong_buffer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_output_pingpong_buffer.sv
// Double-buffered output stage for the lift unit.
// Coefficients arrive one per cycle and are packed lane-interleaved into one of
// two banks. A full bank is drained as wide rows while the other bank fills.
module lift_output_pingpong_buffer #(
  parameter int DATA_W = 30,
  parameter int LANES  = 8,
  parameter int DEPTH  = 64,
  localparam int ROW_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [LANES*DATA_W-1:0]   rd_data,
  output logic [ROW_W-1:0]          rd_row,
  output logic                      rd_last,
  output logic                      err
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANES - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  // Per-bank bookkeeping
  bank_state_e              state_q    [2];
  bank_state_e              state_d    [2];
  logic [ROW_W-1:0]         last_row_q [2];
  logic [ROW_W-1:0]         last_row_d [2];
  // Set once the final row of a bank has been loaded into the output register
  logic                     spent_q    [2];
  logic                     spent_d    [2];

  // Writer side
  logic                     wsel_q, wsel_d;
  logic [LANE_W-1:0]        wl_q, wl_d;
  logic [ROW_W-1:0]         wr_q, wr_d;
  logic                     err_q, err_d;

  // Reader side
  logic                     rsel_q, rsel_d;
  logic [ROW_W-1:0]         rr_q, rr_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [LANES*DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [ROW_W-1:0]         rd_row_q, rd_row_d;
  logic                     rd_last_q, rd_last_d;

  // Storage: one asynchronous-read RAM per lane per bank
  logic [DATA_W-1:0]        bank_ram [2][DEPTH][LANES];

  logic                     wr_fire;
  logic                     lane_end;
  logic                     row_end;
  logic                     wr_close;
  logic                     rd_xfer;
  logic                     rd_free;
  logic                     ld_sel;
  logic [ROW_W-1:0]         ld_row;
  logic                     ld_ok;
  logic                     ld_is_last;
  logic [LANES*DATA_W-1:0]  ld_data;

  // Handshake qualifiers and the candidate row for the output register
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    wr_ready   = 1'b0;
    ld_data    = '0;
    wr_ready   = ((state_q[wsel_q] == BANK_EMPTY) || (state_q[wsel_q] == BANK_FILLING)) && !rst;
    wr_fire    = wr_valid && wr_ready;
    lane_end   = (wl_q == LANE_MAX);
    row_end    = (wr_q == ROW_MAX);
    wr_close   = wr_fire && ((lane_end && row_end) || wr_last);

    rd_xfer    = rd_valid_q && rd_ready;
    rd_free    = rd_xfer && rd_last_q;
    // Freeing the current bank lets the other bank load in the same cycle
    ld_sel     = rd_free ? ~rsel_q : rsel_q;
    ld_row     = rd_free ? '0 : rr_q;
    ld_ok      = (!rd_valid_q || rd_ready) && !spent_q[ld_sel] &&
                 ((state_q[ld_sel] == BANK_FULL) || (state_q[ld_sel] == BANK_DRAINING));
    ld_is_last = (ld_row == last_row_q[ld_sel]);
    for (int k = 0; k < LANES; k++) begin
      ld_data[k*DATA_W +: DATA_W] = bank_ram[ld_sel][ld_row][k];
    end
  end

  // Next-state logic for the writer, the reader and both bank state machines
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_d[b]    = state_q[b];
      last_row_d[b] = last_row_q[b];
      spent_d[b]    = spent_q[b];
    end
    wsel_d     = wsel_q;
    wl_d       = wl_q;
    wr_d       = wr_q;
    err_d      = err_q;
    rsel_d     = rsel_q;
    rr_d       = rr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_row_d   = rd_row_q;
    rd_last_d  = rd_last_q;

    // Writer only ever touches an EMPTY/FILLING bank, the reader only a
    // FULL/DRAINING one, so the two halves below never collide.
    if (wr_fire) begin
      if (state_q[wsel_q] == BANK_EMPTY) begin
        state_d[wsel_q] = BANK_FILLING;
      end
      if (wr_last && !lane_end) begin
        err_d = 1'b1;
      end
      if (wr_close) begin
        state_d[wsel_q]    = BANK_FULL;
        last_row_d[wsel_q] = wr_q;
        wsel_d             = ~wsel_q;
        wl_d               = '0;
        wr_d               = '0;
      end else if (lane_end) begin
        wl_d = '0;
        wr_d = wr_q + ROW_W'(1);
      end else begin
        wl_d = wl_q + LANE_W'(1);
      end
    end

    if (rd_free) begin
      state_d[rsel_q] = BANK_EMPTY;
      spent_d[rsel_q] = 1'b0;
    end
    rsel_d = ld_sel;
    rr_d   = ld_row;

    if (ld_ok) begin
      rd_valid_d      = 1'b1;
      rd_data_d       = ld_data;
      rd_row_d        = ld_row;
      rd_last_d       = ld_is_last;
      state_d[ld_sel] = BANK_DRAINING;
      if (ld_is_last) begin
        spent_d[ld_sel] = 1'b1;
        rr_d            = '0;
      end else begin
        rr_d = ld_row + ROW_W'(1);
      end
    end else if (rd_xfer) begin
      rd_valid_d = 1'b0;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        state_q[b]    <= BANK_EMPTY;
        last_row_q[b] <= '0;
        spent_q[b]    <= 1'b0;
      end
      wsel_q     <= 1'b0;
      wl_q       <= '0;
      wr_q       <= '0;
      err_q      <= 1'b0;
      rsel_q     <= 1'b0;
      rr_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_row_q   <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        state_q[b]    <= state_d[b];
        last_row_q[b] <= last_row_d[b];
        spent_q[b]    <= spent_d[b];
      end
      wsel_q     <= wsel_d;
      wl_q       <= wl_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      rsel_q     <= rsel_d;
      rr_q       <= rr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_row_q   <= rd_row_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Coefficient RAM write port
  always_ff @(posedge clk) begin
    // NOTE: the RAM is deliberately not reset; bank state alone decides which rows are meaningful.
    if (wr_fire) begin
      bank_ram[wsel_q][wr_q][wl_q] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_row   = rd_row_q;
  assign rd_last  = rd_last_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lift_output_pingpong_buffer.sv
// Self-checking bench for lift_output_pingpong_buffer with a queue-based model
// that packs accepted coefficients into expected rows per bank.
module tb_lift_output_pingpong_buffer;

  localparam int DATA_W = 30;
  localparam int LANES  = 8;
  localparam int DEPTH  = 4;
  localparam int ROW_W  = $clog2(DEPTH);
  localparam int ROWB   = LANES * DATA_W;

  localparam int RD_ON   = 0;
  localparam int RD_OFF  = 1;
  localparam int RD_RAND = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              rd_valid;
  logic              rd_ready;
  logic [ROWB-1:0]   rd_data;
  logic [ROW_W-1:0]  rd_row;
  logic              rd_last;
  logic              err;

  lift_output_pingpong_buffer #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data (wr_data),
    .wr_last (wr_last),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .rd_row  (rd_row),
    .rd_last (rd_last),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ROWB-1:0] data;
    logic [ROWB-1:0] mask;
    int              row;
    bit              last;
  } row_t;

  typedef struct {
    logic [ROWB-1:0] data;
    int              row;
    bit              last;
  } log_t;

  row_t              exp_q[$];
  logic [DATA_W-1:0] cur_words[$];
  log_t              out_log[$];
  int                closed_m = 0;
  bit                err_m = 1'b0;

  int                cyc = 0;
  int                first_rise = -1;
  int                accept_cyc = 0;
  int                n_acc = 0;
  int                rd_mode = RD_ON;

  bit                prev_hold = 1'b0;
  bit                prev_valid = 1'b0;
  logic [ROWB-1:0]   prev_data;
  logic [ROW_W-1:0]  prev_row;
  logic              prev_last;
  row_t              cmp_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] lane_of(input logic [ROWB-1:0] d, input int k);
    return d[k*DATA_W +: DATA_W];
  endfunction

  // A closed bank turns into ceil(n/LANES) rows; lanes never written stay unchecked
  function automatic void close_bank();
    int n  = cur_words.size();
    int nr = (n + LANES - 1) / LANES;
    for (int r = 0; r < nr; r++) begin
      row_t e;
      e.data = '0;
      e.mask = '0;
      for (int k = 0; k < LANES; k++) begin
        if (r * LANES + k < n) begin
          e.data[k*DATA_W +: DATA_W] = cur_words[r * LANES + k];
          e.mask[k*DATA_W +: DATA_W] = '1;
        end
      end
      e.row  = r;
      e.last = (r == nr - 1);
      exp_q.push_back(e);
    end
    cur_words.delete();
    closed_m++;
  endfunction

  // Compare process: judges the coming edge from stable pre-edge values
  always @(negedge clk) begin
    if (rst) begin
      check("wr_ready_in_rst", 256'(wr_ready), 256'(0));
      exp_q.delete();
      cur_words.delete();
      closed_m   = 0;
      err_m      = 1'b0;
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold)
        check("hold_stable", 256'({rd_valid, rd_last, rd_row, rd_data}),
              256'({1'b1, prev_last, prev_row, prev_data}));
      check("wr_ready", 256'(wr_ready), 256'(closed_m < 2));
      check("err", 256'(err), 256'(err_m));
      if (rd_valid) check("rd_valid_has_row", 256'(exp_q.size() != 0), 256'(1));
      if (rd_valid && rd_ready && exp_q.size() != 0) begin
        cmp_e = exp_q.pop_front();
        check("rd_data", 256'(rd_data & cmp_e.mask), 256'(cmp_e.data));
        check("rd_row", 256'(rd_row), 256'(cmp_e.row));
        check("rd_last", 256'(rd_last), 256'(cmp_e.last));
        out_log.push_back('{data: rd_data, row: int'(rd_row), last: rd_last});
        if (cmp_e.last) closed_m--;
      end
      if (wr_valid && wr_ready) begin
        if (wr_last && (cur_words.size() % LANES != LANES - 1)) err_m = 1'b1;
        cur_words.push_back(wr_data);
        if (wr_last || cur_words.size() == LANES * DEPTH) close_bank();
      end
      if (rd_valid && !prev_valid && first_rise < 0) first_rise = cyc;
      prev_hold  = rd_valid && !rd_ready;
      prev_valid = rd_valid;
      prev_data  = rd_data;
      prev_row   = rd_row;
      prev_last  = rd_last;
    end
  end

  // Consumer back-pressure driver
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        RD_ON:   rd_ready = 1'b1;
        RD_OFF:  rd_ready = 1'b0;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    bit ok = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = l;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        accept_cyc = cyc;
        break;
      end
    end
    check("wr_accept_in_time", 256'(ok), 256'(1));
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    n_acc++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_valid) break;
    end
    check("drain_done", 256'(exp_q.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("rst_rd_valid", 256'(rd_valid), 256'(0));
    check("rst_rd_data", 256'(rd_data), 256'(0));
    check("rst_rd_row", 256'(rd_row), 256'(0));
    check("rst_rd_last", 256'(rd_last), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_wr_ready_after", 256'(wr_ready), 256'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int lb;
    int base;
    int a31;
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();

    // 1: 32 words streamed, reader always ready
    rd_mode    = RD_ON;
    first_rise = -1;
    lb         = out_log.size();
    for (int i = 0; i < 32; i++) send(DATA_W'(i), 1'b0);
    a31 = accept_cyc;
    wait_drain();
    check("t1_latency", 256'(first_rise - a31), 256'(2));
    check("t1_rows", 256'(out_log.size() - lb), 256'(4));
    for (int r = 0; r < 4; r++) begin
      check("t1_row_idx", 256'(out_log[lb+r].row), 256'(r));
      check("t1_row_last", 256'(out_log[lb+r].last), 256'(r == 3));
      for (int k = 0; k < LANES; k++)
        check("t1_lane", 256'(lane_of(out_log[lb+r].data, k)), 256'(r * 8 + k));
    end

    // 2: both banks fill with reader stalled, then release
    rd_mode = RD_OFF;
    lb      = out_log.size();
    base    = n_acc;
    fork
      begin
        for (int i = 0; i < 96; i++) send(DATA_W'(1000 + i), 1'b0);
      end
      begin
        repeat (90) @(negedge clk);
        check("t2_stall_words", 256'(n_acc - base), 256'(64));
        check("t2_wr_ready_low", 256'(wr_ready), 256'(0));
        check("t2_no_output", 256'(out_log.size() - lb), 256'(0));
        rd_mode = RD_ON;
      end
    join
    wait_drain();
    check("t2_rows", 256'(out_log.size() - lb), 256'(12));
    for (int r = 0; r < 12; r++)
      for (int k = 0; k < LANES; k++)
        check("t2_lane", 256'(lane_of(out_log[lb+r].data, k)), 256'(1000 + r * 8 + k));
    check("t2_third_bank_first", 256'(lane_of(out_log[lb+8].data, 0)), 256'(1064));

    // 3: aligned early close after 16 words
    lb = out_log.size();
    for (int i = 0; i < 16; i++) send(DATA_W'(2000 + i), i == 15);
    wait_drain();
    check("t3_err", 256'(err), 256'(0));
    check("t3_rows", 256'(out_log.size() - lb), 256'(2));
    check("t3_row0_last", 256'(out_log[lb].last), 256'(0));
    check("t3_row1_last", 256'(out_log[lb+1].last), 256'(1));
    check("t3_row1_idx", 256'(out_log[lb+1].row), 256'(1));
    lb = out_log.size();
    for (int i = 0; i < 32; i++) send(DATA_W'(3000 + i), 1'b0);
    wait_drain();
    check("t3_next_row", 256'(out_log[lb].row), 256'(0));
    check("t3_next_lane0", 256'(lane_of(out_log[lb].data, 0)), 256'(3000));

    // 4: misaligned wr_last on word 10
    lb = out_log.size();
    for (int i = 0; i < 11; i++) send(DATA_W'(4000 + i), i == 10);
    wait_drain();
    check("t4_err_set", 256'(err), 256'(1));
    check("t4_rows", 256'(out_log.size() - lb), 256'(2));
    check("t4_row1_last", 256'(out_log[lb+1].last), 256'(1));
    check("t4_row1_lane0", 256'(lane_of(out_log[lb+1].data, 0)), 256'(4008));
    check("t4_row1_lane2", 256'(lane_of(out_log[lb+1].data, 2)), 256'(4010));
    for (int i = 0; i < 32; i++) send(DATA_W'(4100 + i), 1'b0);
    wait_drain();
    check("t4_err_sticky", 256'(err), 256'(1));
    do_reset();

    // 5: random valid gaps and random back-pressure, 1000 words
    rd_mode = RD_RAND;
    lb      = out_log.size();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send(DATA_W'($urandom), i == 999);
    end
    wait_drain();
    check("t5_rows", 256'(out_log.size() - lb), 256'(125));
    check("t5_err", 256'(err), 256'(0));

    // 6: reset while B0 drains and B1 fills
    rd_mode = RD_OFF;
    for (int i = 0; i < 37; i++) send(DATA_W'(5000 + i), 1'b0);
    idle(3);
    check("t6_draining", 256'(rd_valid), 256'(1));
    do_reset();
    rd_mode = RD_ON;
    lb      = out_log.size();
    for (int i = 0; i < 32; i++) send(DATA_W'(6000 + i), 1'b0);
    wait_drain();
    check("t6_rows", 256'(out_log.size() - lb), 256'(4));
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < LANES; k++)
        check("t6_lane", 256'(lane_of(out_log[lb+r].data, k)), 256'(6000 + r * 8 + k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
